sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the core's instruction-fetch port and its data port.
- Sits between the IF stage / scoreboard memory interface and the unified memory macro.
- Grants one requester per cycle and stalls the loser.
- Routes read data back to the owner and holds it stable until that owner's next read returns.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_STARVE, 4, consecutive denied instruction-request cycles after which the instruction port wins once.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_en  in  1  instruction read request.
- inst_addr  in  ADDR_W  instruction address.
- inst_stall  out  1  request not granted this cycle; requester holds inst_en/inst_addr.
- inst_rvalid  out  1  inst_rdata carries new data this cycle.
- inst_rdata  out  DATA_W  instruction read data; held between returns.
- data_en  in  1  data request.
- data_wen  in  DATA_W/8  byte write enables; 0 means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_stall  out  1  data request not granted this cycle.
- data_rvalid  out  1  data_rdata carries new read data this cycle.
- data_rdata  out  DATA_W  data read data; held between returns.
- sram_en  out  1  SRAM access enable.
- sram_wen  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read grant.
- conflict_cnt  out  32  count of cycles in which both ports requested; wraps at 2^32.

Behaviour:
- Grant is combinational, same cycle as the request.
- If only one port requests, that port is granted.
- If both request, the data port wins unless starve_cnt == MAX_STARVE, in which case the instruction port wins.
- The granted port's fields drive sram_*.
- For an instruction grant, sram_wen = 0.
- With no grant: sram_en = 0, sram_wen = 0; sram_addr and sram_wdata are don't-care but driven by the instruction port.
- Stalls: inst_stall = inst_en & ~inst_grant; data_stall = data_en & ~data_grant. Stall never asserts without a request.
- starve_cnt (register):
  - increments when inst_en is set and the instruction port is denied; saturates at MAX_STARVE;
  - clears on any instruction grant;
  - holds when inst_en is low.
- Owner register: values NONE, INST, DATA.
  - Next value = INST on an instruction grant.
  - Next value = DATA on a data grant with data_wen == 0.
  - Otherwise NONE; a write grant produces no response.
- Response cycle (owner != NONE):
  - the owner's rvalid = 1;
  - the owner's rdata = sram_rdata, and sram_rdata is also latched into that port's hold register.
- In all other cycles, rvalid = 0 and rdata = hold register.
- Back-to-back: a new grant is issued in the same cycle a previous response returns; peak throughput is one access per cycle.
- Requester contract: while stalled, inputs stay stable. The arbiter does not buffer denied requests.
- conflict_cnt increments each cycle with inst_en & data_en.
- Reset:
  - owner = NONE, starve_cnt = 0, both hold registers = 0, conflict_cnt = 0;
  - all outputs 0 during reset: sram_en, sram_wen, both stalls and both rvalids are forced low.
  - Reset asserted in the cycle after a read grant drops that response: no rvalid, and the hold register is not updated.
- MAX_STARVE = 0 means the instruction port always wins ties.

Decomposition:
- Shared defines header holds:
  - owner encoding (OWN_NONE = 2'd0, OWN_INST = 2'd1, OWN_DATA = 2'd2);
  - default ADDR_W/DATA_W.
- One natural sub-module: sram_resp_hold, the per-port rvalid/hold-register unit (latches rdata on response, outputs held value otherwise). It is instantiated twice.
- Grant logic and starvation counter stay in the top module.

Test Plan:
- Inst-only read: inst_en=1, addr=0xBFC00000, SRAM returns 0x3C080001 next cycle → sram_en=1, inst_stall=0; next cycle inst_rvalid=1, inst_rdata=0x3C080001; held after inst_en drops.
- Conflict, data read wins: both request, data addr=0x100, rdata 0xDEADBEEF → data granted, inst_stall=1 for 1 cycle, then inst granted; data_rvalid with 0xDEADBEEF; conflict_cnt=1.
- Starvation: both held high for 6 cycles, MAX_STARVE=4 → data granted cycles 0–3, inst granted cycle 4, data granted cycle 5; starve_cnt clears after cycle 4.
- Data write: data_en=1, wen=4'b0011, wdata=0x1234ABCD → sram_wen=4'b0011; no data_rvalid next cycle; data_rdata unchanged.
- Back-to-back reads: alternating single requests on 4 consecutive cycles → each response has rvalid exactly one cycle after its grant, on the correct port; no lost cycles.
- Reset mid-read: instruction grant, reset=1 next cycle → inst_rvalid=0, inst_rdata=0, conflict_cnt=0, sram_en=0.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and defaults for the SRAM port arbiter
package sram_port_arbiter_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_STARVE = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    // Starvation counter needs to hold 0..max_starve; keep at least one bit.
    function automatic int starve_w(input int max_starve);
        return (max_starve < 1) ? 1 : $clog2(max_starve + 1);
    endfunction

endpackage

// File: rtl/sram_resp_hold.sv
// rtl/sram_resp_hold.sv - per-port read response valid and held read data
module sram_resp_hold
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_resp,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_hold;
    logic              w_take;

    // A reset landing on the response cycle discards that response.
    assign w_take = i_resp & ~i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold <= '0;
        end else if (w_take) begin
            r_hold <= i_rdata;
        end
    end

    always_comb begin
        o_rvalid = w_take;
        o_rdata  = r_hold;
        if (i_reset) begin
            o_rdata = '0;
        end else if (w_take) begin
            o_rdata = i_rdata;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-port SRAM between instruction and data ports
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STARVE = DEF_MAX_STARVE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_inst_en,
    input  logic [ADDR_W-1:0]   i_inst_addr,
    output logic                o_inst_stall,
    output logic                o_inst_rvalid,
    output logic [DATA_W-1:0]   o_inst_rdata,
    input  logic                i_data_en,
    input  logic [DATA_W/8-1:0] i_data_wen,
    input  logic [ADDR_W-1:0]   i_data_addr,
    input  logic [DATA_W-1:0]   i_data_wdata,
    output logic                o_data_stall,
    output logic                o_data_rvalid,
    output logic [DATA_W-1:0]   o_data_rdata,
    output logic                o_sram_en,
    output logic [DATA_W/8-1:0] o_sram_wen,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic [DATA_W-1:0]   o_sram_wdata,
    input  logic [DATA_W-1:0]   i_sram_rdata,
    output logic [31:0]         o_conflict_cnt
);

    localparam int             SW         = starve_w(MAX_STARVE);
    localparam logic [SW-1:0]  STARVE_TOP = SW'(MAX_STARVE);

    owner_e          r_owner;
    owner_e          w_owner_next;
    logic [SW-1:0]   r_starve_cnt;
    logic [SW-1:0]   w_starve_next;
    logic [31:0]     r_conflict_cnt;
    logic            w_both;
    logic            w_inst_grant;
    logic            w_data_grant;
    logic            w_inst_resp;
    logic            w_data_resp;

    // Data normally wins a tie; a starved instruction port takes one turn.
    assign w_both       = i_inst_en & i_data_en;
    assign w_inst_grant = i_inst_en & (~i_data_en | (r_starve_cnt == STARVE_TOP));
    assign w_data_grant = i_data_en & ~w_inst_grant;

    always_comb begin
        o_sram_en    = 1'b0;
        o_sram_wen   = '0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_inst_stall = 1'b0;
        o_data_stall = 1'b0;
        if (!i_reset) begin
            o_sram_en    = w_inst_grant | w_data_grant;
            o_sram_addr  = w_data_grant ? i_data_addr : i_inst_addr;
            o_sram_wen   = w_data_grant ? i_data_wen : '0;
            o_sram_wdata = w_data_grant ? i_data_wdata : '0;
            o_inst_stall = i_inst_en & ~w_inst_grant;
            o_data_stall = i_data_en & ~w_data_grant;
        end
    end

    always_comb begin
        w_owner_next = OWN_NONE;
        if (w_inst_grant) begin
            w_owner_next = OWN_INST;
        end else if (w_data_grant && (i_data_wen == '0)) begin
            w_owner_next = OWN_DATA;
        end
    end

    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_inst_grant) begin
            w_starve_next = '0;
        end else if (i_inst_en && (r_starve_cnt != STARVE_TOP)) begin
            w_starve_next = r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner        <= OWN_NONE;
            r_starve_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_owner      <= w_owner_next;
            r_starve_cnt <= w_starve_next;
            if (w_both) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign o_conflict_cnt = i_reset ? 32'd0 : r_conflict_cnt;
    assign w_inst_resp    = (r_owner == OWN_INST);
    assign w_data_resp    = (r_owner == OWN_DATA);

    sram_resp_hold #(
        .DATA_W (DATA_W)
    ) u_inst_hold (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_resp   (w_inst_resp),
        .i_rdata  (i_sram_rdata),
        .o_rvalid (o_inst_rvalid),
        .o_rdata  (o_inst_rdata)
    );

    sram_resp_hold #(
        .DATA_W (DATA_W)
    ) u_data_hold (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_resp   (w_data_resp),
        .i_rdata  (i_sram_rdata),
        .o_rvalid (o_data_rvalid),
        .o_rdata  (o_data_rdata)
    );

endmodule
